clint_responder: RTL

- Memory-mapped core-local interruptor (CLINT) slave at the responder end of the CPU data/instruction memory port.
- Decodes requests that fall in the CLINT window.
- Holds msip, a 64-bit mtime counter and a 64-bit mtimecmp comparator.
- Returns read data with a fixed one-cycle response, and drives the software and timer interrupt lines into the core's CSR unit.

---
 rtl/clint_responder.sv | 151 +++++++++++++++
 1 files changed

// File: rtl/clint_responder.sv
// Core-local interruptor responder: msip, 64-bit mtime/mtimecmp, fixed one-cycle response.
// Define CLINT_RTC_PRESCALE_EN to tick mtime once per rtc_div clocks instead of every clock.
module clint_responder #(
    parameter logic [31:0] clint_base_addr = 32'h0200_0000,
    parameter logic [31:0] clint_top_addr  = 32'h0200_C000,
    parameter int unsigned rtc_div         = 10
) (
    input  logic        clock,
    input  logic        reset,
    input  logic        clint_valid,
    input  logic        clint_instr,
    input  logic [31:0] clint_addr,
    input  logic [31:0] clint_wdata,
    input  logic [3:0]  clint_wstrb,
    output logic [31:0] clint_rdata,
    output logic        clint_ready,
    output logic        clint_msip,
    output logic        clint_mtip,
    output logic [63:0] clint_mtime
);

    localparam logic [31:0] OffMsip      = 32'h0000_0000;
    localparam logic [31:0] OffMtimecmpL = 32'h0000_4000;
    localparam logic [31:0] OffMtimecmpH = 32'h0000_4004;
    localparam logic [31:0] OffMtimeL    = 32'h0000_BFF8;
    localparam logic [31:0] OffMtimeH    = 32'h0000_BFFC;

    typedef enum logic {StIdle, StResp} state_e;

    state_e      state_q, state_d;
    logic [31:0] rdata_q, rdata_d;
    logic        msip_q, msip_d;
    logic        mtip_q, mtip_d;
    logic [63:0] mtime_q, mtime_d;
    logic [63:0] mtimecmp_q, mtimecmp_d;
    logic        tick;

    logic [31:0] offset;
    logic        in_window;
    logic        rd_req;
    logic        wr_en;

    assign offset    = clint_addr - clint_base_addr;
    assign in_window = (clint_addr >= clint_base_addr) && (clint_addr < clint_top_addr);
    // Fetches are always reads, whatever the strobes say.
    assign rd_req    = clint_valid && (clint_instr || (clint_wstrb == 4'b0000));
    assign wr_en     = clint_valid && !clint_instr && (clint_wstrb != 4'b0000) && in_window;

    function automatic logic [31:0] merge_bytes(input logic [31:0] old_word,
                                                input logic [31:0] new_word,
                                                input logic [3:0]  strb);
        logic [31:0] res;
        for (int i = 0; i < 4; i++) begin
            res[i*8 +: 8] = strb[i] ? new_word[i*8 +: 8] : old_word[i*8 +: 8];
        end
        return res;
    endfunction

`ifdef CLINT_RTC_PRESCALE_EN
    localparam int unsigned CntW = (rtc_div > 1) ? $clog2(rtc_div) : 1;
    localparam logic [CntW-1:0] CntMax = CntW'(rtc_div - 1);

    logic [CntW-1:0] prescale_q, prescale_d;

    always_comb begin
        tick       = (prescale_q == CntMax);
        prescale_d = tick ? '0 : prescale_q + 1'b1;
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            prescale_q <= '0;
        end else begin
            prescale_q <= prescale_d;
        end
    end
`else
    assign tick = 1'b1;
`endif

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (clint_valid) state_d = StResp;
            StResp:  if (!clint_valid) state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Read data reflects register contents before this edge's update.
    always_comb begin
        rdata_d = '0;
        if (rd_req && in_window) begin
            case (offset)
                OffMsip:      rdata_d = {31'b0, msip_q};
                OffMtimecmpL: rdata_d = mtimecmp_q[31:0];
                OffMtimecmpH: rdata_d = mtimecmp_q[63:32];
                OffMtimeL:    rdata_d = mtime_q[31:0];
                OffMtimeH:    rdata_d = mtime_q[63:32];
                default:      rdata_d = '0;
            endcase
        end
    end

    always_comb begin
        msip_d     = msip_q;
        mtimecmp_d = mtimecmp_q;
        mtime_d    = mtime_q + {63'b0, tick};
        if (wr_en) begin
            case (offset)
                OffMsip: if (clint_wstrb[0]) msip_d = clint_wdata[0];
                OffMtimecmpL: mtimecmp_d[31:0] =
                    merge_bytes(mtimecmp_q[31:0], clint_wdata, clint_wstrb);
                OffMtimecmpH: mtimecmp_d[63:32] =
                    merge_bytes(mtimecmp_q[63:32], clint_wdata, clint_wstrb);
                // A software write to mtime overrides that cycle's increment entirely.
                OffMtimeL: mtime_d = {mtime_q[63:32],
                                      merge_bytes(mtime_q[31:0], clint_wdata, clint_wstrb)};
                OffMtimeH: mtime_d = {merge_bytes(mtime_q[63:32], clint_wdata, clint_wstrb),
                                      mtime_q[31:0]};
                default: ;
            endcase
        end
        mtip_d = (mtime_d >= mtimecmp_d);
    end

    always_ff @(posedge clock) begin
        if (!reset) begin
            state_q    <= StIdle;
            rdata_q    <= '0;
            msip_q     <= 1'b0;
            mtip_q     <= 1'b0;
            mtime_q    <= '0;
            mtimecmp_q <= '1;
        end else begin
            state_q    <= state_d;
            rdata_q    <= rdata_d;
            msip_q     <= msip_d;
            mtip_q     <= mtip_d;
            mtime_q    <= mtime_d;
            mtimecmp_q <= mtimecmp_d;
        end
    end

    assign clint_ready = (state_q == StResp);
    assign clint_rdata = rdata_q;
    assign clint_msip  = msip_q;
    assign clint_mtip  = mtip_q;
    assign clint_mtime = mtime_q;

endmodule
